// File: rtl/fsm_result_monitor.sv
// Result-side observer for the main FSM: checks final value, hold stability and timeout.
// Optional running-sum check is built when FSM_MON_SUM_EN is defined.
module fsm_result_monitor #(
  parameter logic [4:0]  EXPECT     = 5'd21,
  parameter int unsigned TIMEOUT    = 1000,
  parameter int unsigned HOLD_CYC   = 2,
  parameter logic [15:0] EXPECT_SUM = 16'd0
) (
  input  logic        clk_p,
  input  logic        reset_n,
  input  logic        start,
  input  logic [4:0]  out,
  input  logic        ready,
  output logic        done,
  output logic        correct,
  output logic        timeout,
  output logic        stable_err,
  output logic [4:0]  result,
  output logic [15:0] cycles
);

  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYC - 1);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  localparam logic [15:0] TO_VAL  = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HOLD,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic          ready_q, ready_d;
  logic [15:0]   cyc_q, cyc_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          done_q, done_d;
  logic          correct_q, correct_d;
  logic          timeout_q, timeout_d;
  logic          stable_q, stable_d;
  logic [4:0]    result_q, result_d;
  logic [15:0]   cycles_q, cycles_d;
  logic [15:0]   sum_q, sum_d;
  logic          sum_ok;
  logic [15:0]   cyc_inc;

`ifdef FSM_MON_SUM_EN
  assign sum_ok = (sum_q == EXPECT_SUM);
`else
  logic unused_sum;
  assign unused_sum = ^EXPECT_SUM ^ ^sum_q;
  assign sum_ok = 1'b1;
`endif

  assign cyc_inc = (cyc_q == 16'hFFFF) ? cyc_q : cyc_q + 16'd1;

  // Next-state and verdict logic; a rise on the last RUN cycle beats timeout.
  always_comb begin
    state_d   = state_q;
    ready_d   = ready_q;
    cyc_d     = cyc_q;
    hold_d    = hold_q;
    done_d    = done_q;
    correct_d = correct_q;
    timeout_d = timeout_q;
    stable_d  = stable_q;
    result_d  = result_q;
    cycles_d  = cycles_q;
    sum_d     = sum_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          cyc_d     = 16'd0;
          ready_d   = 1'b0;
          done_d    = 1'b0;
          correct_d = 1'b0;
          timeout_d = 1'b0;
          stable_d  = 1'b0;
          result_d  = 5'd0;
          cycles_d  = 16'd0;
          sum_d     = 16'd0;
        end
      end
      S_RUN: begin
        cyc_d   = cyc_inc;
        ready_d = ready;
`ifdef FSM_MON_SUM_EN
        sum_d   = sum_q + {11'd0, out};
`endif
        if (ready && !ready_q) begin
          result_d = out;
          cycles_d = cyc_inc;
          hold_d   = HOLD_INIT;
          state_d  = S_HOLD;
        end else if (cyc_q == TO_LAST) begin
          timeout_d = 1'b1;
          cycles_d  = TO_VAL;
          done_d    = 1'b1;
          correct_d = 1'b0;
          state_d   = S_DONE;
        end
      end
      S_HOLD: begin
        if ((out != result_q) || !ready) begin
          stable_d = 1'b1;
        end
        if (hold_q == '0) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          correct_d = (result_q == EXPECT) & ~timeout_q
                      & ~stable_d & sum_ok;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      S_DONE: begin
        if (!start) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk_p or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      ready_q   <= 1'b0;
      cyc_q     <= 16'd0;
      hold_q    <= '0;
      done_q    <= 1'b0;
      correct_q <= 1'b0;
      timeout_q <= 1'b0;
      stable_q  <= 1'b0;
      result_q  <= 5'd0;
      cycles_q  <= 16'd0;
      sum_q     <= 16'd0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      cyc_q     <= cyc_d;
      hold_q    <= hold_d;
      done_q    <= done_d;
      correct_q <= correct_d;
      timeout_q <= timeout_d;
      stable_q  <= stable_d;
      result_q  <= result_d;
      cycles_q  <= cycles_d;
      sum_q     <= sum_d;
    end
  end

  assign done       = done_q;
  assign correct    = correct_q;
  assign timeout    = timeout_q;
  assign stable_err = stable_q;
  assign result     = result_q;
  assign cycles     = cycles_q;

endmodule

// File: tb/tb_fsm_result_monitor.sv
// Directed bench for fsm_result_monitor: vector table plus reset/early-ready sequence.
// Two instances share stimulus and differ only in EXPECT_SUM.
`timescale 1ns/1ps
module tb_fsm_result_monitor;

  localparam int TO = 16;
  localparam int HC = 2;

  logic        clk_p = 1'b0;
  logic        reset_n;
  logic        start;
  logic        ready;
  logic [4:0]  out;

  logic        done_a, correct_a, timeout_a, stable_a;
  logic [4:0]  result_a;
  logic [15:0] cycles_a;
  logic        done_b, correct_b, timeout_b, stable_b;
  logic [4:0]  result_b;
  logic [15:0] cycles_b;

  always #5 clk_p = ~clk_p;

  fsm_result_monitor #(
    .EXPECT(5'd21), .TIMEOUT(TO), .HOLD_CYC(HC),
    .EXPECT_SUM(16'd63)
  ) u_a (
    .clk_p(clk_p), .reset_n(reset_n), .start(start),
    .out(out), .ready(ready),
    .done(done_a), .correct(correct_a), .timeout(timeout_a),
    .stable_err(stable_a), .result(result_a), .cycles(cycles_a)
  );

  fsm_result_monitor #(
    .EXPECT(5'd21), .TIMEOUT(TO), .HOLD_CYC(HC),
    .EXPECT_SUM(16'd62)
  ) u_b (
    .clk_p(clk_p), .reset_n(reset_n), .start(start),
    .out(out), .ready(ready),
    .done(done_b), .correct(correct_b), .timeout(timeout_b),
    .stable_err(stable_b), .result(result_b), .cycles(cycles_b)
  );

  typedef struct {
    string       name;
    logic [4:0]  o_first;
    logic [4:0]  o_pre;
    logic [4:0]  o_rise;
    logic [4:0]  o_hold;
    int          rise;
    logic        r_hold;
    logic        ok_base;
    logic        to;
    logic        st;
    logic [4:0]  res;
    logic [15:0] cyc;
  } vec_t;

  vec_t vt[7];
  int   n_pass = 0;
  int   n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic logic sum_ok(input logic [15:0] s,
                                  input logic [15:0] want);
`ifdef FSM_MON_SUM_EN
    return s == want;
`else
    return 1'b1;
`endif
  endfunction

  task automatic run_vec(input vec_t v);
    int          done_at;
    int          exp_at;
    int          last_run;
    logic [15:0] sm;
    start = 1'b0;
    ready = 1'b0;
    out   = 5'd0;
    repeat (2) @(negedge clk_p);
    start = 1'b1;
    @(posedge clk_p);
    @(negedge clk_p);
    start    = 1'b0;
    done_at  = 0;
    sm       = 16'd0;
    last_run = (v.rise != 0) ? v.rise : TO;
    for (int k = 1; k <= 40 && done_at == 0; k++) begin
      if (v.rise != 0 && k > v.rise) begin
        out   = v.o_hold;
        ready = v.r_hold;
      end else if (k == v.rise) begin
        out   = v.o_rise;
        ready = 1'b1;
      end else begin
        out   = (k == 1) ? v.o_first : v.o_pre;
        ready = 1'b0;
      end
      if (k <= last_run) sm += {11'd0, out};
      @(negedge clk_p);
      if (done_a) done_at = k;
    end
    exp_at = (v.rise != 0) ? v.rise + HC : TO;
    chk({v.name, ".done_edge"}, done_at, exp_at);
    chk({v.name, ".correct"}, {31'd0, correct_a},
        {31'd0, v.ok_base & sum_ok(sm, 16'd63)});
    chk({v.name, ".correct62"}, {31'd0, correct_b},
        {31'd0, v.ok_base & sum_ok(sm, 16'd62)});
    chk({v.name, ".timeout"}, {31'd0, timeout_a}, {31'd0, v.to});
    chk({v.name, ".stable_err"}, {31'd0, stable_a}, {31'd0, v.st});
    chk({v.name, ".result"}, {27'd0, result_a}, {27'd0, v.res});
    chk({v.name, ".cycles"}, {16'd0, cycles_a}, {16'd0, v.cyc});
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".done"}, {31'd0, done_a}, 32'd0);
    chk({nm, ".correct"}, {31'd0, correct_a}, 32'd0);
    chk({nm, ".timeout"}, {31'd0, timeout_a}, 32'd0);
    chk({nm, ".stable_err"}, {31'd0, stable_a}, 32'd0);
    chk({nm, ".result"}, {27'd0, result_a}, 32'd0);
    chk({nm, ".cycles"}, {16'd0, cycles_a}, 32'd0);
  endtask

  initial begin
    vt[0] = '{"nominal",  5'd0, 5'd0,  5'd21, 5'd21, 7,  1'b1,
              1'b1, 1'b0, 1'b0, 5'd21, 16'd7};
    vt[1] = '{"wrongval", 5'd0, 5'd0,  5'd20, 5'd20, 7,  1'b1,
              1'b0, 1'b0, 1'b0, 5'd20, 16'd7};
    vt[2] = '{"outchg",   5'd0, 5'd0,  5'd21, 5'd22, 7,  1'b1,
              1'b0, 1'b0, 1'b1, 5'd21, 16'd7};
    vt[3] = '{"timeout",  5'd0, 5'd0,  5'd0,  5'd0,  0,  1'b0,
              1'b0, 1'b1, 1'b0, 5'd0,  16'd16};
    vt[4] = '{"rdydrop",  5'd3, 5'd3,  5'd21, 5'd21, 5,  1'b0,
              1'b0, 1'b0, 1'b1, 5'd21, 16'd5};
    vt[5] = '{"riselast", 5'd0, 5'd0,  5'd21, 5'd21, 16, 1'b1,
              1'b1, 1'b0, 1'b0, 5'd21, 16'd16};
    vt[6] = '{"sum63",    5'd0, 5'd21, 5'd21, 5'd21, 4,  1'b1,
              1'b1, 1'b0, 1'b0, 5'd21, 16'd4};

    reset_n = 1'b0;
    start   = 1'b0;
    ready   = 1'b0;
    out     = 5'd0;
    #12;
    chk_zero("reset");
    @(negedge clk_p);
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vt[i]);

    // ready already high when start is sampled, then reset mid-HOLD
    @(negedge clk_p);
    start = 1'b1;
    ready = 1'b1;
    out   = 5'd21;
    @(posedge clk_p);
    @(negedge clk_p);
    start = 1'b0;
    @(negedge clk_p);
    chk("early.cycles", {16'd0, cycles_a}, 32'd1);
    chk("early.result", {27'd0, result_a}, 32'd21);
    chk("early.done", {31'd0, done_a}, 32'd0);
    @(posedge clk_p);
    #2 reset_n = 1'b0;
    #1 chk_zero("midreset");
    @(negedge clk_p);
    reset_n = 1'b1;
    ready   = 1'b0;
    repeat (4) @(negedge clk_p);
    chk("postreset.done", {31'd0, done_a}, 32'd0);
    chk("postreset.cycles", {16'd0, cycles_a}, 32'd0);
    run_vec(vt[0]);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/fsm_result_monitor.md
# fsm_result_monitor

Observer/checker on the result side of the `main` FSM interface: watches `start`, `out[4:0]` and `ready` from the FSM under test and produces the `correct` verdict plus a cycle count. It sits beside the FSM in the testbench or on-chip self-test wrapper and consumes exactly what the FSM produces. Checks:
- the final result against a parameterised expected value;
- that the result holds stable after `ready`;
- that `ready` arrives before a timeout.

## Interface
Parameters:
- `EXPECT`, 5'd21, expected value of `out` at the `ready` rising edge
- `TIMEOUT`, 1000, maximum RUN cycles before declaring timeout (≥2)
- `HOLD_CYC`, 2, cycles after `ready` rise during which `out`/`ready` must stay stable (≥1)
- `EXPECT_SUM`, 16'd0, expected running sum of `out` (used only with `FSM_MON_SUM_EN`)

Ports:
- `clk_p`  in  1  single clock, all state on rising edge
- `reset_n`  in  1  one clock; reset is asynchronous and active-low
- `start`  in  1  run request, same signal driven to the FSM
- `out`  in  5  FSM result bus
- `ready`  in  1  FSM completion flag
- `done`  out  1  verdict valid
- `correct`  out  1  pass verdict, meaningful when `done`=1
- `timeout`  out  1  `ready` never rose within `TIMEOUT` cycles
- `stable_err`  out  1  `out` changed or `ready` dropped during the hold window
- `result`  out  5  `out` captured at the `ready` rise
- `cycles`  out  16  RUN cycles from start to `ready` rise, saturating at 16'hFFFF

## Operation
- States: IDLE, RUN, HOLD, DONE. Internal regs: `ready_q`, `cyc`[15:0], `hold_cnt`.
- IDLE: if `start`=1 → RUN, `cyc`<=0, `ready_q`<=0, clear `timeout`, `stable_err`, `done`, `correct`, `result`, `cycles`.
- RUN, every edge:
  - `cyc`<=`cyc`+1, saturating at 16'hFFFF; `ready_q`<=`ready`.
  - Rise = `ready` & ~`ready_q`. Because `ready_q` is 0 on entry, `ready` already high in the first RUN cycle counts as a rise.
  - On rise: `result`<=`out`, `cycles`<=`cyc`+1 (saturating), `hold_cnt`<=`HOLD_CYC`-1, → HOLD.
  - Else if `cyc`==`TIMEOUT`-1: `timeout`<=1, `cycles`<=`TIMEOUT`, → DONE.
  - A rise on the timeout cycle takes priority over the timeout.
- HOLD, every edge:
  - If `out`!=`result` or `ready`=0, then `stable_err`<=1 (sticky).
  - If `hold_cnt`==0 → DONE, else decrement.
- DONE:
  - `done`=1.
  - `correct` = (`result`==`EXPECT`) & ~`timeout` & ~`stable_err` [& sum match, see Configuration]. It is registered on entry to DONE.
  - Stay in DONE while `start`=1. When `start`=0 → IDLE; `done`, `correct` and the other outputs hold their values until the next IDLE→RUN.
- `start` dropping during RUN or HOLD is ignored; the run completes.

## Timing
- Reset (async, `reset_n`=0): state IDLE; `done`=0, `correct`=0, `timeout`=0, `stable_err`=0, `result`=0, `cycles`=0. Internal `cyc`, `hold_cnt`, `ready_q` and the sum are also 0.
- Reset mid-run aborts immediately; no verdict is produced.
- Start sampled at edge N → RUN from edge N.
- `ready` first seen high at edge N+k (k≥1) → `cycles`=k, HOLD entered at that edge.
- `done` and `correct` rise exactly `HOLD_CYC` edges after the HOLD entry edge.
- Timeout: `done` rises at edge N+`TIMEOUT` with `cycles`=`TIMEOUT`, `correct`=0.
- All outputs are registered; no combinational input-to-output path.

## Configuration
- `FSM_MON_SUM_EN` defined:
  - A 16-bit `sum` (wrapping) accumulates zero-extended `out` on every RUN edge, including the rise edge; it is cleared on IDLE→RUN.
  - `correct` additionally requires `sum`==`EXPECT_SUM`.
- Undefined: no accumulator is built and `correct` ignores `EXPECT_SUM`.

## Test plan
- Reset, `start`=1, FSM model raises `ready` with `out`=21 at the 7th RUN edge and holds for 4 cycles → `cycles`=7, `result`=21, `done`=1 two edges later, `correct`=1.
- Same run but `out`=20 → `done`=1, `correct`=0, `stable_err`=0, `timeout`=0.
- `ready` rises with `out`=21, then `out` changes to 22 on the next edge (`HOLD_CYC`=2) → `stable_err`=1, `correct`=0.
- `TIMEOUT`=16, `ready` never asserts → `done` at the 16th edge after start, `timeout`=1, `cycles`=16, `correct`=0.
- `ready` already high when `start` is sampled → rise is detected on the first RUN edge, `cycles`=1; `reset_n` pulsed low mid-HOLD → all outputs read 0 asynchronously and the monitor returns to IDLE.
- With `FSM_MON_SUM_EN` and `EXPECT_SUM`=16'd63: `out` sequence 0,21,21,21 with `ready` on the 4th edge → `correct`=1. The same run with `EXPECT_SUM`=16'd62 → `correct`=0.
